i2c_adc_responder: RTL and testbench

I2C_ADC_RESPONDER -- requirements
Module: i2c_adc_responder

---
 rtl/i2c_adc_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_adc_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_adc_responder.sv
// I2C target exposing a writable config byte and four 12-bit ADC channels read as 2-byte words.
// Optional build macro I2C_RESP_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_adc_responder #(
  parameter logic [6:0] ADDR    = 7'h28,
  parameter logic [7:0] CFG_RST = 8'hF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] ch0,
  input  logic [11:0] ch1,
  input  logic [11:0] ch2,
  input  logic [11:0] ch3,
  output logic [7:0]  cfg,
  output logic        busy
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(8);

  typedef enum logic [2:0] {
    IDLE, ADDR_S, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_e;

  state_e           state_q;
  logic [1:0]       scl_sync_q, sda_sync_q;
  logic             scl_f, sda_f, scl_prev_q, sda_prev_q;
  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [7:0]       shreg_q, cfg_q, lo_q;
  logic [1:0]       ptr_q, pick_c;
  logic             sda_oe_q, busy_q, rw_q, ack_q, half_q;
  logic [11:0]      ch_mux;
  logic [7:0]       byte0_c;

  // First enabled channel at or after 'from', wrapping; channel 0 when none enabled.
  function automatic logic [1:0] pick_ch(input logic [3:0] en, input logic [1:0] from);
    logic [1:0] sel, idx;
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = from + 2'(i);
      if (en[idx]) sel = idx;
    end
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
    end
  end

  // A single-cycle pulse never gains a 2-of-3 majority.
  assign scl_f = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                 (scl_hist_q[0] & scl_hist_q[1]);
  assign sda_f = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                 (sda_hist_q[0] & sda_hist_q[1]);
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  assign pick_c = pick_ch(cfg_q[7:4], ptr_q);

  always_comb begin
    ch_mux = ch0;
    case (pick_c)
      2'd0:    ch_mux = ch0;
      2'd1:    ch_mux = ch1;
      2'd2:    ch_mux = ch2;
      default: ch_mux = ch3;
    endcase
  end

  assign byte0_c = {2'b00, pick_c, ch_mux[11:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      cfg_q      <= CFG_RST;
      lo_q       <= '0;
      ptr_q      <= 2'd0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      half_q     <= 1'b0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      if (stop_det) begin
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else if (start_det) begin
        state_q   <= ADDR_S;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR_S, WR_DATA: begin
            if (scl_rise) begin
              shreg_q   <= {shreg_q[6:0], sda_f};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              if (state_q == WR_DATA) begin
                cfg_q    <= shreg_q;
                ptr_q    <= pick_ch(shreg_q[7:4], 2'd0);
                sda_oe_q <= 1'b1;
                state_q  <= WR_ACK;
              end else if (shreg_q[7:1] == ADDR) begin
                rw_q     <= shreg_q[0];
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= ADDR_ACK;
              end else begin
                busy_q   <= 1'b0;
                state_q  <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                shreg_q  <= byte0_c;
                lo_q     <= ch_mux[7:0];
                ptr_q    <= pick_c + 2'd1;
                half_q   <= 1'b0;
                sda_oe_q <= ~byte0_c[7];
                state_q  <= RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= WR_DATA;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                state_q   <= RD_ACK;
              end else begin
                shreg_q  <= {shreg_q[6:0], 1'b0};
                sda_oe_q <= ~shreg_q[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              ack_q <= ~sda_f;
            end else if (scl_fall) begin
              if (!ack_q) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else if (!half_q) begin
                shreg_q  <= lo_q;
                half_q   <= 1'b1;
                sda_oe_q <= ~lo_q[7];
                state_q  <= RD_DATA;
              end else begin
                shreg_q  <= byte0_c;
                lo_q     <= ch_mux[7:0];
                ptr_q    <= pick_c + 2'd1;
                half_q   <= 1'b0;
                sda_oe_q <= ~byte0_c[7];
                state_q  <= RD_DATA;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe = sda_oe_q;
  assign busy   = busy_q;
  assign cfg    = cfg_q;

endmodule

// File: tb/tb_i2c_adc_responder.sv
// Bench for i2c_adc_responder: bit-banged I2C initiator, expected read bytes queued as a scoreboard.
module tb_i2c_adc_responder;

  localparam int Q = 100;

  logic        clk, rst, scl, sda_m, sda_line, sda_oe, busy;
  logic [11:0] ch [4];
  logic [7:0]  cfg;
  logic [7:0]  exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        watch, oe_seen, busy_seen;

  typedef struct {
    logic [7:0] cfg_v;
    logic [1:0] c0, c1, c2;
  } vec_t;
  vec_t vt [6];

  assign sda_line = sda_m & ~sda_oe;

  i2c_adc_responder dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .ch0(ch[0]), .ch1(ch[1]), .ch2(ch[2]), .ch3(ch[3]), .cfg(cfg), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (watch) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; acked = ~sda_line; #Q; scl = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda_line; #Q; scl = 1'b0; #Q;
    end
    sda_m = nack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
  endtask

  // Read one byte and compare it against the head of the scoreboard.
  task automatic rd_check(input string name, input logic nack);
    logic [7:0] b, e;
    recv_byte(nack, b);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected nothing (scoreboard empty)", name, b);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(b), 32'(e));
    end
  endtask

  task automatic push_word(input logic [1:0] c);
    logic [11:0] v;
    v = ch[c];
    exp_q.push_back({2'b00, c, v[11:8]});
    exp_q.push_back(v[7:0]);
  endtask

  task automatic wr_cfg(input logic [7:0] v);
    logic a;
    bus_start();
    send_byte(8'h50, a); chk("wr addr ack", 32'(a), 32'd1);
    send_byte(v, a);     chk("wr data ack", 32'(a), 32'd1);
    bus_stop();
    chk("cfg after write", 32'(cfg), 32'(v));
  endtask

  initial begin
    logic a;
    logic [7:0] b;
    rst = 1'b0; scl = 1'b1; sda_m = 1'b1; watch = 1'b0; oe_seen = 1'b0; busy_seen = 1'b0;
    for (int k = 0; k < 4; k++) ch[k] = 12'h000;
    vt[0] = '{8'h80, 2'd3, 2'd3, 2'd3};
    vt[1] = '{8'h00, 2'd0, 2'd0, 2'd0};
    vt[2] = '{8'hF0, 2'd0, 2'd1, 2'd2};
    vt[3] = '{8'hA0, 2'd1, 2'd3, 2'd1};
    vt[4] = '{8'h50, 2'd0, 2'd2, 2'd0};
    vt[5] = '{8'h30, 2'd0, 2'd1, 2'd0};
    #53;
    chk("reset sda_oe", 32'(sda_oe), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset cfg", 32'(cfg), 32'hF0);
    rst = 1'b1; #10;

    // Single config write.
    bus_start();
    send_byte(8'h50, a); chk("w30 addr ack", 32'(a), 32'd1);
    send_byte(8'h30, a); chk("w30 data ack", 32'(a), 32'd1);
    chk("w30 busy before stop", 32'(busy), 32'd1);
    bus_stop();
    chk("w30 cfg", 32'(cfg), 32'h30);
    chk("w30 busy after stop", 32'(busy), 32'd0);

    // Two words from ch0 then ch1 with fixed data.
    wr_cfg(8'hF0);
    ch[0] = 12'hABC; ch[1] = 12'h123;
    exp_q.push_back(8'h0A); exp_q.push_back(8'hBC);
    exp_q.push_back(8'h11); exp_q.push_back(8'h23);
    bus_start();
    send_byte(8'h51, a); chk("rd addr ack", 32'(a), 32'd1);
    rd_check("rd b0", 1'b0); rd_check("rd b1", 1'b0);
    rd_check("rd b2", 1'b0); rd_check("rd b3", 1'b1);
    chk("rd sda released after nack", 32'(sda_oe), 32'd0);
    chk("rd busy after nack", 32'(busy), 32'd0);
    bus_stop();

    // Foreign address must be ignored entirely.
    oe_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
    bus_start();
    send_byte(8'h52, a); chk("foreign addr no ack", 32'(a), 32'd0);
    send_byte(8'h11, a); chk("foreign data no ack", 32'(a), 32'd0);
    bus_stop();
    watch = 1'b0;
    chk("foreign sda_oe never set", 32'(oe_seen), 32'd0);
    chk("foreign busy never set", 32'(busy_seen), 32'd0);
    chk("foreign cfg untouched", 32'(cfg), 32'hF0);

    // Channel stepping across enable masks.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 4; k++) ch[k] = 12'($urandom);
      wr_cfg(vt[v].cfg_v);
      push_word(vt[v].c0); push_word(vt[v].c1); push_word(vt[v].c2);
      bus_start();
      send_byte(8'h51, a); chk("tbl addr ack", 32'(a), 32'd1);
      chk("tbl busy", 32'(busy), 32'd1);
      for (int j = 0; j < 6; j++) rd_check($sformatf("tbl%0d byte%0d", v, j), 1'(j == 5));
      chk("tbl released", 32'(sda_oe), 32'd0);
      bus_stop();
    end

    // Repeated START from write into read, then pointer persistence across transactions.
    ch[0] = 12'h111; ch[1] = 12'h5A5; ch[2] = 12'hC3C; ch[3] = 12'h777;
    bus_start();
    send_byte(8'h50, a); chk("rs wr addr ack", 32'(a), 32'd1);
    send_byte(8'h60, a); chk("rs wr data ack", 32'(a), 32'd1);
    bus_start();
    send_byte(8'h51, a); chk("rs rd addr ack", 32'(a), 32'd1);
    chk("rs cfg", 32'(cfg), 32'h60);
    push_word(2'd1);
    rd_check("rs w0 hi", 1'b0); rd_check("rs w0 lo", 1'b1);
    bus_stop();
    push_word(2'd2); push_word(2'd1);
    bus_start();
    send_byte(8'h51, a); chk("persist addr ack", 32'(a), 32'd1);
    rd_check("persist w1 hi", 1'b0); rd_check("persist w1 lo", 1'b0);
    rd_check("persist w2 hi", 1'b0); rd_check("persist w2 lo", 1'b1);
    bus_stop();

    // Reset while driving a 0 data bit, then ignore traffic without START.
    wr_cfg(8'h30);
    ch[0] = 12'h000;
    bus_start();
    send_byte(8'h51, a); chk("rst rd addr ack", 32'(a), 32'd1);
    chk("rst precondition sda_oe", 32'(sda_oe), 32'd1);
    rst = 1'b0; #1;
    chk("rst async sda_oe", 32'(sda_oe), 32'd0);
    chk("rst cfg", 32'(cfg), 32'hF0);
    chk("rst busy", 32'(busy), 32'd0);
    #20; rst = 1'b1; #9;
    oe_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sda_m = 1'b0; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    end
    bus_stop();
    watch = 1'b0;
    chk("post-rst sda_oe idle", 32'(oe_seen), 32'd0);
    chk("post-rst busy idle", 32'(busy_seen), 32'd0);
    wr_cfg(8'h70);

`ifdef I2C_RESP_GLITCH_FILTER_EN
    // One-clock SCL pulse mid-byte must not shift an extra bit.
    bus_start();
    send_byte(8'h50, a); chk("glitch addr ack", 32'(a), 32'd1);
    b = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      if (i == 4) begin
        @(negedge clk); #3; scl = 1'b1; #10; scl = 1'b0;
      end
    end
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; a = ~sda_line; #Q; scl = 1'b0; #Q;
    chk("glitch data ack", 32'(a), 32'd1);
    bus_stop();
    chk("glitch cfg", 32'(cfg), 32'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
